uart_rx: RTL

Asynchronous 8N1 UART receiver for the 27 MHz / 115200 baud serial link; it is the counterpart to the design's UART transmitter. It synchronizes the raw `rx` pin and detects the start-bit falling edge. It samples each bit at its nominal centre, deserializes LSB-first, and presents each byte with a one-cycle `valid` strobe. It also flags framing errors and rejects start-bit glitches.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Synchronizes the raw serial line, checks the
//            start bit at its mid-point, samples each data bit at its nominal
//            centre (LSB first) and checks the stop bit. Good bytes are
//            presented with a one-cycle valid strobe; a low stop bit gives a
//            one-cycle frame_err strobe and the receiver then waits for the
//            line to return high, so a held break yields a single error.
// Ports    : clk        system clock, rising edge
//            rst        asynchronous, active-low reset
//            rx         serial line, idle high, asynchronous to clk
//            data[7:0]  last correctly framed byte, held until the next one
//            valid      one-cycle pulse, data is new in the same cycle
//            frame_err  one-cycle pulse, stop bit was sampled low
//            busy       high whenever a frame is being received
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int          CLKS      = FREQ / BAUD;
  localparam int          HALF      = CLKS / 2;
  localparam logic [15:0] CLKS_LAST = 16'(CLKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // busy is a pure decode of the state register, so it changes only on
  // clock edges and carries no combinational path from rx.
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Two-flop synchronizer; only rx_s feeds any decision.
      rx_m      <= rx;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= 16'd0;
          if (!rx_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          // Re-check the line half a bit in; a high level means the falling
          // edge was a glitch and is dropped silently.
          if (cnt == HALF_LAST) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (cnt == CLKS_LAST) begin
            cnt   <= 16'd0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (cnt == CLKS_LAST) begin
            cnt <= 16'd0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_BRK: begin
          // Hold off until the line is released so a break reports once.
          cnt <= 16'd0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          cnt   <= 16'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
